// File: rtl/ctr_gen.sv
// rtl/ctr_gen.sv - multicycle accumulator controller with NCOP coprocessor channels
// Optional coprocessor-wait watchdog: CTR_GEN_TIMEOUT_EN (limit TMO cycles).
module ctr_gen #(
    parameter int OPW  = 8,
    parameter int NCOP = 2,
    parameter int TMO  = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  zflag,
    input  logic [OPW-1:0]                        opcode,
    input  logic [NCOP-1:0]                       cop_done,
    output logic                                  muxPC,
    output logic                                  muxMAR,
    output logic [1:0]                            muxACC,
    output logic                                  loadMAR,
    output logic                                  loadPC,
    output logic                                  loadACC,
    output logic                                  loadMDR,
    output logic                                  loadIR,
    output logic                                  MemRW,
    output logic [1:0]                            opALU,
    output logic                                  cop_reset,
    output logic [NCOP-1:0]                       cop_load,
    output logic [((NCOP > 1) ? $clog2(NCOP) : 1)-1:0] cop_sel,
    output logic                                  illegal,
    output logic                                  cop_timeout
);

    localparam int CSW = (NCOP > 1) ? $clog2(NCOP) : 1;

    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_OR    = OPW'(2);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(3);
    localparam logic [OPW-1:0] OP_JUMPZ = OPW'(4);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(5);
    localparam logic [OPW-1:0] OP_STORE = OPW'(6);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(9);
    localparam logic [OPW-1:0] OP_NEG   = OPW'(10);
    localparam logic [OPW-1:0] OP_COP0  = OPW'(16);
    localparam logic [OPW-1:0] OP_COPN  = OPW'(16 + NCOP);

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        ADD1, ADD2, OR1, OR2, LOAD1, LOAD2,
        STORE1, JUMP, NEG1, NEG2,
        COP_RD, COP_CLR, COP_LD1, COP_LD2, COP_WAIT, COP_WB
    } state_t;

    state_t         state;
    state_t         state_n;
    logic           is_cop;
    logic           unmapped;
    logic [CSW-1:0] cop_idx;
    logic           wd_expire;

    // Channel k lives at 16+k, so the low bits of the opcode are the index.
    always_comb begin
        is_cop  = (opcode == OP_MUL) || ((opcode >= OP_COP0) && (opcode < OP_COPN));
        cop_idx = (opcode == OP_MUL) ? '0 : opcode[CSW-1:0];
        unmapped = 1'b0;
        case (opcode)
            OP_ADD, OP_OR, OP_JUMP, OP_JUMPZ, OP_LOAD, OP_STORE, OP_NEG: unmapped = 1'b0;
            default: unmapped = !is_cop;
        endcase
    end

`ifdef CTR_GEN_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] wd_cnt;

    // Count holds the number of completed wait cycles; expiry ends the TMO-th one.
    assign wd_expire = (wd_cnt == CW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            cop_timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == COP_WAIT) ? wd_cnt + 1'b1 : '0;
            if ((state == COP_WAIT) && !cop_done[cop_sel] && wd_expire)
                cop_timeout <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    // Watchdog not built; a negative limit is meaningless, so this is constant 0.
    assign cop_timeout = (TMO < 0);
`endif

    always_comb begin
        state_n = state;
        case (state)
            FETCH1:   state_n = FETCH2;
            FETCH2:   state_n = FETCH3;
            FETCH3:   state_n = DECODE;
            DECODE: begin
                case (opcode)
                    OP_ADD:   state_n = ADD1;
                    OP_OR:    state_n = OR1;
                    OP_JUMP:  state_n = JUMP;
                    OP_JUMPZ: state_n = zflag ? JUMP : FETCH1;
                    OP_LOAD:  state_n = LOAD1;
                    OP_STORE: state_n = STORE1;
                    OP_NEG:   state_n = NEG1;
                    default:  state_n = is_cop ? COP_RD : FETCH1;
                endcase
            end
            ADD1:     state_n = ADD2;
            OR1:      state_n = OR2;
            LOAD1:    state_n = LOAD2;
            NEG1:     state_n = NEG2;
            COP_RD:   state_n = COP_CLR;
            COP_CLR:  state_n = COP_LD1;
            COP_LD1:  state_n = COP_LD2;
            COP_LD2:  state_n = COP_WAIT;
            COP_WAIT: begin
                if (cop_done[cop_sel])
                    state_n = COP_WB;
                else if (wd_expire)
                    state_n = FETCH1;
            end
            default:  state_n = FETCH1;
        endcase
    end

    // Moore outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH1;
            cop_sel   <= '0;
            illegal   <= 1'b0;
            muxPC     <= 1'b0;
            muxMAR    <= 1'b0;
            muxACC    <= 2'b00;
            loadMAR   <= 1'b1;
            loadPC    <= 1'b1;
            loadACC   <= 1'b0;
            loadMDR   <= 1'b0;
            loadIR    <= 1'b0;
            MemRW     <= 1'b0;
            opALU     <= 2'b00;
            cop_reset <= 1'b0;
            cop_load  <= '0;
        end else begin
            state   <= state_n;
            illegal <= (state == DECODE) && unmapped;
            if ((state == DECODE) && is_cop)
                cop_sel <= cop_idx;

            muxPC     <= 1'b0;
            muxMAR    <= 1'b0;
            muxACC    <= 2'b00;
            loadMAR   <= 1'b0;
            loadPC    <= 1'b0;
            loadACC   <= 1'b0;
            loadMDR   <= 1'b0;
            loadIR    <= 1'b0;
            MemRW     <= 1'b0;
            opALU     <= 2'b00;
            cop_reset <= 1'b0;
            cop_load  <= '0;
            case (state_n)
                FETCH1:  begin loadMAR <= 1'b1; loadPC <= 1'b1; end
                FETCH2:  loadMDR <= 1'b1;
                FETCH3:  loadIR <= 1'b1;
                DECODE:  begin muxMAR <= 1'b1; loadMAR <= 1'b1; end
                ADD1, OR1, LOAD1: loadMDR <= 1'b1;
                ADD2:    begin loadACC <= 1'b1; opALU <= 2'b01; end
                OR2:     loadACC <= 1'b1;
                LOAD2:   begin loadACC <= 1'b1; muxACC <= 2'b01; end
                STORE1:  MemRW <= 1'b1;
                JUMP:    begin muxPC <= 1'b1; loadPC <= 1'b1; end
                NEG1:    begin loadMDR <= 1'b1; opALU <= 2'b11; end
                NEG2:    begin loadACC <= 1'b1; opALU <= 2'b11; end
                COP_RD:  begin loadMDR <= 1'b1; cop_reset <= 1'b1; end
                COP_CLR: cop_reset <= 1'b1;
                COP_LD1, COP_LD2: cop_load[cop_sel] <= 1'b1;
                COP_WB:  begin loadACC <= 1'b1; muxACC <= 2'b10; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_gen.sv
// tb/tb_ctr_gen.sv - scoreboard bench for ctr_gen (NCOP=2, TMO=8)
module tb_ctr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zflag = 1'b0;
    logic [7:0] opcode = 8'd0;
    logic [1:0] cop_done = 2'b00;
    logic       muxPC, muxMAR, loadMAR, loadPC, loadACC, loadMDR, loadIR, MemRW;
    logic [1:0] muxACC, opALU, cop_load;
    logic       cop_reset, illegal, cop_timeout;
    logic [0:0] cop_sel;

    ctr_gen #(.OPW(8), .NCOP(2), .TMO(8)) dut (
        .clk(clk), .rst(rst), .zflag(zflag), .opcode(opcode), .cop_done(cop_done),
        .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC), .loadMAR(loadMAR),
        .loadPC(loadPC), .loadACC(loadACC), .loadMDR(loadMDR), .loadIR(loadIR),
        .MemRW(MemRW), .opALU(opALU), .cop_reset(cop_reset), .cop_load(cop_load),
        .cop_sel(cop_sel), .illegal(illegal), .cop_timeout(cop_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] M_MUXPC  = 18'h20000;
    localparam logic [17:0] M_MUXMAR = 18'h10000;
    localparam logic [17:0] M_ACCCOP = 18'h08000;
    localparam logic [17:0] M_ACCMDR = 18'h04000;
    localparam logic [17:0] M_LMAR   = 18'h02000;
    localparam logic [17:0] M_LPC    = 18'h01000;
    localparam logic [17:0] M_LACC   = 18'h00800;
    localparam logic [17:0] M_LMDR   = 18'h00400;
    localparam logic [17:0] M_LIR    = 18'h00200;
    localparam logic [17:0] M_MEMRW  = 18'h00100;
    localparam logic [17:0] M_NEG    = 18'h000C0;
    localparam logic [17:0] M_ADD    = 18'h00040;
    localparam logic [17:0] M_CRST   = 18'h00020;
    localparam logic [17:0] M_CLD1   = 18'h00010;
    localparam logic [17:0] M_CLD0   = 18'h00008;
    localparam logic [17:0] M_SEL    = 18'h00004;
    localparam logic [17:0] M_ILL    = 18'h00002;
    localparam logic [17:0] M_TMO    = 18'h00001;

    typedef struct {
        string       tag;
        logic [17:0] w;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_sel = 1'b0;
    logic exp_tmo = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [17:0] m);
        exp_t e;
        e.tag = tag;
        e.w   = m | (exp_sel ? M_SEL : 18'h0) | (exp_tmo ? M_TMO : 18'h0);
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk(e.tag, {14'd0, muxPC, muxMAR, muxACC, loadMAR, loadPC, loadACC, loadMDR,
                        loadIR, MemRW, opALU, cop_reset, cop_load, cop_sel, illegal,
                        cop_timeout}, {14'd0, e.w});
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        exp_sel = 1'b0;
        exp_tmo = 1'b0;
        push(tag, M_LMAR | M_LPC);
        step();
        rst = 1'b0;
    endtask

    task automatic push_fetch_decode();
        push("fetch2", M_LMDR);
        push("fetch3", M_LIR);
        push("decode", M_MUXMAR | M_LMAR);
    endtask

    // Entered while the DUT sits in FETCH1; ends with the next FETCH1 checked.
    task automatic run(input logic [7:0] op, input logic z);
        logic ill;
        ill    = 1'b0;
        opcode = op;
        zflag  = z;
        push_fetch_decode();
        case (op)
            8'd1:  begin push("add1", M_LMDR); push("add2", M_LACC | M_ADD); end
            8'd2:  begin push("or1", M_LMDR); push("or2", M_LACC); end
            8'd5:  begin push("load1", M_LMDR); push("load2", M_LACC | M_ACCMDR); end
            8'd6:  push("store1", M_MEMRW);
            8'd3:  push("jump", M_MUXPC | M_LPC);
            8'd4:  if (z) push("jumpz", M_MUXPC | M_LPC);
            8'd10: begin push("neg1", M_LMDR | M_NEG); push("neg2", M_LACC | M_NEG); end
            default: ill = 1'b1;
        endcase
        push(ill ? "fetch1_illegal" : "fetch1", M_LMAR | M_LPC | (ill ? M_ILL : 18'h0));
        drain();
    endtask

    task automatic do_cop(input logic [7:0] op, input int n, input logic give,
                          input logic [1:0] base);
        logic [7:0]  k;
        logic [17:0] ld;
        opcode   = op;
        cop_done = base;
        k        = op - 8'd16;
        push_fetch_decode();
        exp_sel = (op == 8'd9) ? 1'b0 : k[0];
        ld      = exp_sel ? M_CLD1 : M_CLD0;
        push("cop_rd", M_LMDR | M_CRST);
        push("cop_clr", M_CRST);
        push("cop_ld1", ld);
        push("cop_ld2", ld);
        drain();
        for (int i = 1; i <= n; i++) begin
            push("cop_wait", 18'h0);
            step();
            if (give && i == n) cop_done[exp_sel] = 1'b1;
        end
        if (give) begin
            push("cop_wb", M_LACC | M_ACCCOP);
            step();
            cop_done = base;
            push("fetch1_after_wb", M_LMAR | M_LPC);
            step();
        end else begin
`ifdef CTR_GEN_TIMEOUT_EN
            exp_tmo = 1'b1;
            push("fetch1_timeout", M_LMAR | M_LPC);
            step();
`endif
        end
        cop_done = 2'b00;
    endtask

    initial begin
        do_reset("reset_state");
        run(8'd1, 1'b0);
        opcode = 8'd1;
        push_fetch_decode();
        push("add1_pre_reset", M_LMDR);
        drain();
        do_reset("reset_mid_add");
        run(8'd4, 1'b0);
        run(8'd4, 1'b1);
        run(8'd2, 1'b0);
        run(8'd5, 1'b0);
        run(8'd6, 1'b0);
        run(8'd3, 1'b0);
        run(8'd10, 1'b0);
        do_cop(8'd17, 3, 1'b1, 2'b01);
        run(8'd2, 1'b0);
        do_cop(8'd9, 1, 1'b1, 2'b11);
        run(8'h7F, 1'b0);
        run(8'd18, 1'b0);
        run(8'd0, 1'b0);
        run(8'd1, 1'b1);
`ifdef CTR_GEN_TIMEOUT_EN
        do_cop(8'd16, 8, 1'b1, 2'b00);
        do_cop(8'd9, 8, 1'b0, 2'b00);
        run(8'd1, 1'b0);
        do_reset("reset_clears_timeout");
`else
        do_cop(8'd9, 200, 1'b0, 2'b00);
        do_reset("reset_mid_wait");
`endif
        run(8'd5, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
